// File: rtl/ppc_types.sv
// Shared PowerPC result types: CR0/XER side-effect bundle and the GPR write-back payload.
package ppc_types;

    typedef struct packed {
        logic        xer_valid;
        logic        CR0_valid;
        logic        so;
        logic [0:31] xer;
    } cond_exception_t;

    typedef struct packed {
        logic [0:4]      reg_addr;
        logic [0:31]     result;
        cond_exception_t cr0_xer;
    } gpr_result_t;

endpackage

// File: rtl/gpr_result_fifo_ring_buffer_mem.sv
// DEPTH x WIDTH storage for the result FIFO: one synchronous write port, one asynchronous read port.
module ring_buffer_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/gpr_result_fifo.sv
// In-order result buffer between one execution unit and its write-back arbiter slot.
// Optional macro GPR_RESULT_FIFO_BYPASS_EN: an empty buffer forwards the input straight to the output.
module gpr_result_fifo
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RS_ID_WIDTH-1:0]     in_rs_id,
    input  logic [4:0]                 in_reg_addr,
    input  logic [31:0]                in_result,
    input  cond_exception_t            in_cr0_xer,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RS_ID_WIDTH-1:0]     out_rs_id,
    output logic [4:0]                 out_reg_addr,
    output logic [31:0]                out_result,
    output cond_exception_t            out_cr0_xer,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        gpr_result_t            res;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic   w_empty;
    logic   w_full;
    logic   w_bypass;
    logic   w_push;
    logic   w_pop;
    entry_t w_in_entry;
    entry_t w_head_entry;
    entry_t w_out_entry;
    logic [EW-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

`ifdef GPR_RESULT_FIFO_BYPASS_EN
    assign w_bypass = w_empty & in_valid & out_ready & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Ready never depends on out_ready, so a full buffer rejects a push even while popping.
    assign in_ready  = ~w_full & ~flush;
    assign out_valid = (~w_empty | w_bypass) & ~flush;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_in_entry.rs_id            = in_rs_id;
    assign w_in_entry.res.reg_addr     = in_reg_addr;
    assign w_in_entry.res.result       = in_result;
    assign w_in_entry.res.cr0_xer      = in_cr0_xer;

    // A bypassed result is written and then skipped by advancing both pointers together.
    ring_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_in_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign w_head_entry = entry_t'(w_rdata);

    always_comb begin
        w_out_entry = w_head_entry;
        if (w_empty) begin
`ifdef GPR_RESULT_FIFO_BYPASS_EN
            w_out_entry = w_in_entry;
`else
            w_out_entry = '0;
`endif
        end
    end

    assign out_rs_id    = w_out_entry.rs_id;
    assign out_reg_addr = w_out_entry.res.reg_addr;
    assign out_result   = w_out_entry.res.result;
    assign out_cr0_xer  = w_out_entry.res.cr0_xer;
    assign count        = r_count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/gpr_result_fifo.md
# gpr_result_fifo

Per-execution-unit result buffer between an execution unit's GPR result output and one slot of the write-back arbiter's GPR input array. It decouples the unit from arbitration stalls by holding up to DEPTH completed results (tag, destination register, value, CR0/XER side effects) in order, with valid/ready handshakes on both sides. A synchronous flush discards all buffered results on pipeline redirect.

## Interface
- RS_ID_WIDTH, 5, reservation-station tag width
- DEPTH, 4, entry count; power of two, >= 2
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries this cycle
- in_valid  in  1  producer has a result
- in_ready  out  1  buffer accepts the result
- in_rs_id  in  RS_ID_WIDTH  producer tag
- in_reg_addr  in  5  destination GPR
- in_result  in  32  result value
- in_cr0_xer  in  cond_exception_t  CR0/XER side-effect bundle
- out_valid  out  1  head entry valid, to arbiter gpr_input_valid[k]
- out_ready  in  1  from arbiter gpr_input_ready[k]
- out_rs_id, out_reg_addr, out_result, out_cr0_xer  out  as inputs  head entry fields
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: write pointer, read pointer, occupancy counter, each $clog2(DEPTH) bits (count one wider); pointers wrap DEPTH-1 -> 0.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & ~flush; independent of out_ready (no ready path through the block).
- out_valid = (count != 0) & ~flush; out_* present the head entry; data outputs driven to 0 when count == 0 (without bypass).
- push only: store at write pointer, write pointer +1, count +1. pop only: read pointer +1, count -1. push & pop: both pointers advance, count unchanged.
- Full: push cannot occur, even with a simultaneous pop; producer retries next cycle.
- Empty: pop cannot occur (except bypass case below).
- Ordering strictly FIFO; entries never reordered or merged.
- flush: pointers and count -> 0 next cycle; same-cycle push and pop both suppressed.

## Timing
- Reset: count = 0, pointers = 0, so out_valid = 0, in_ready = 1, all out_* data = 0. Storage array not reset.
- Reset mid-operation behaves as flush; rst has priority over flush and push.
- Latency without bypass: result accepted in cycle N appears at outputs in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- out_* stable while out_valid & ~out_ready (no flush).

## Configuration
- GPR_RESULT_FIFO_BYPASS_EN defined: when count == 0, in_valid = 1, out_ready = 1 and no flush, out_valid = 1 and out_* = in_* combinationally in the same cycle; the result is consumed, not stored (count stays 0). If out_ready = 0 the result is stored normally. When count == 0 and not bypassing, out_* data mirror in_* (out_valid still 0).
- Undefined: no combinational path from in_* to out_*; minimum latency 1 cycle.

## Structure
- cond_exception_t (xer_valid, CR0_valid, so, xer) already in ppc_types; add packed gpr_result_t {reg_addr[0:4], result[0:31], cr0_xer} to ppc_types; rs_id stored alongside because its width is parametric.
- One sub-module: ring_buffer_mem, DEPTH x entry storage, one synchronous write port, one asynchronous read port; pointer/count control stays in gpr_result_fifo.

## Test plan
- Reset then idle: out_valid = 0, in_ready = 1, count = 0 for 5 cycles.
- Push rs_id 3/reg 7/result 0xDEADBEEF with out_ready = 0 -> next cycle out_valid = 1, out_result = 0xDEADBEEF, count = 1; held stable 3 cycles until out_ready = 1.
- DEPTH = 4, fill 4 entries (results 1..4), out_ready = 0 -> in_ready = 0, count = 4; fifth push rejected; drain -> results 1,2,3,4 in order, count reaches 0.
- Full, push and pop in same cycle -> pop accepted, push rejected, count = 3; next cycle push accepted, count = 4; wrap-around data order preserved over 10 entries.
- count = 2, flush asserted with in_valid = 1 and out_ready = 1 -> in_ready = 0, out_valid = 0 that cycle; next cycle count = 0, no entry consumed or stored.
- With GPR_RESULT_FIFO_BYPASS_EN, empty, in_valid = out_ready = 1, result 0x12345678 -> same-cycle out_valid = 1, out_result = 0x12345678, count stays 0; without macro -> out_valid rises next cycle.
